// File: rtl/conv_stream_tx.sv
// AXI-stream transmitter feeding the convolution accelerator: streams W, B and X with TUSER framing.
// Optional CONV_STREAM_TX_TLAST_EN adds OUTPUT_TLAST on the final X word.
module conv_stream_tx #(
   parameter int unsigned INW  = 24,
   parameter int unsigned R    = 16,
   parameter int unsigned C    = 17,
   parameter int unsigned MAXK = 9,
   localparam int unsigned K_BITS      = $clog2(MAXK + 1),
   localparam int unsigned X_ADDR_BITS = $clog2(R * C),
   localparam int unsigned W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic                   start_ready,
   input  logic [K_BITS-1:0]      cfg_K,
   input  logic [INW-1:0]         cfg_B,
   input  logic                   cfg_new_w,
   output logic [W_ADDR_BITS-1:0] W_read_addr,
   input  logic [INW-1:0]         W_data,
   output logic [X_ADDR_BITS-1:0] X_read_addr,
   input  logic [INW-1:0]         X_data,
   output logic [INW-1:0]         OUTPUT_TDATA,
   output logic                   OUTPUT_TVALID,
   output logic [K_BITS:0]        OUTPUT_TUSER,
   input  logic                   OUTPUT_TREADY,
   output logic                   done
`ifdef CONV_STREAM_TX_TLAST_EN
   ,
   output logic                   OUTPUT_TLAST
`endif
);

   localparam int unsigned NX = R * C;

   typedef enum logic [2:0] {StIdle, StSendW, StSendB, StSendX, StDrain, StDone} state_e;
   typedef enum logic [1:0] {SrcW, SrcB, SrcX} src_e;

   state_e state_q, state_d;

   logic [K_BITS-1:0]      k_q;
   logic [W_ADDR_BITS-1:0] kk_q;
   logic [INW-1:0]         b_q;
   logic [W_ADDR_BITS-1:0] w_cnt_q;
   logic [X_ADDR_BITS-1:0] x_cnt_q;

   logic                   in_flight_q;
   src_e                   if_src_q;
   logic [K_BITS:0]        if_user_q;
   logic                   if_last_q;

   logic [INW-1:0]         buf_data_q [2];
   logic [K_BITS:0]        buf_user_q [2];
   logic                   buf_last_q [2];
   logic [1:0]             occ_q;

   logic                   issue;
   src_e                   issue_src;
   logic [K_BITS:0]        issue_user;
   logic                   issue_last;
   logic                   pop;
   logic                   push;
   logic [INW-1:0]         push_data;
   logic [2:0]             pending;
   logic                   can_issue;
   logic                   new_w_ok;

   assign OUTPUT_TVALID = (occ_q != 2'd0);
   assign OUTPUT_TDATA  = buf_data_q[0];
   assign OUTPUT_TUSER  = buf_user_q[0];
   assign W_read_addr   = w_cnt_q;
   assign X_read_addr   = x_cnt_q;

`ifdef CONV_STREAM_TX_TLAST_EN
   assign OUTPUT_TLAST = buf_last_q[0];
`else
   logic unused_last;
   assign unused_last = buf_last_q[0] ^ buf_last_q[1];
`endif

   assign pop       = OUTPUT_TVALID & OUTPUT_TREADY;
   assign push      = in_flight_q;
   // Counting words already buffered or returning next cycle keeps the 2-entry buffer from overflowing.
   assign pending   = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
   assign can_issue = (pending < 3'd2);
   assign new_w_ok  = cfg_new_w && (cfg_K != '0) && (cfg_K <= K_BITS'(MAXK));

   always_comb begin
      push_data = X_data;
      unique case (if_src_q)
         SrcW:    push_data = W_data;
         SrcB:    push_data = b_q;
         default: push_data = X_data;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      issue       = 1'b0;
      issue_src   = SrcX;
      issue_user  = '0;
      issue_last  = 1'b0;
      done        = 1'b0;
      start_ready = 1'b0;
      unique case (state_q)
         StIdle: begin
            start_ready = 1'b1;
            if (start) state_d = new_w_ok ? StSendW : StSendX;
         end
         StSendW: if (can_issue) begin
            issue      = 1'b1;
            issue_src  = SrcW;
            issue_user = (w_cnt_q == '0) ? {k_q, 1'b1} : '0;
            if (w_cnt_q == kk_q - 1'b1) state_d = StSendB;
         end
         StSendB: if (can_issue) begin
            issue     = 1'b1;
            issue_src = SrcB;
            state_d   = StSendX;
         end
         StSendX: if (can_issue) begin
            issue      = 1'b1;
            issue_src  = SrcX;
            issue_last = (x_cnt_q == X_ADDR_BITS'(NX - 1));
            if (issue_last) state_d = StDrain;
         end
         StDrain: if (occ_q == 2'd0 && !in_flight_q) state_d = StDone;
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         k_q         <= '0;
         kk_q        <= '0;
         b_q         <= '0;
         w_cnt_q     <= '0;
         x_cnt_q     <= '0;
         in_flight_q <= 1'b0;
         if_src_q    <= SrcX;
         if_user_q   <= '0;
         if_last_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_flight_q <= issue;
         if_src_q    <= issue_src;
         if_user_q   <= issue_user;
         if_last_q   <= issue_last;
         if (state_q == StIdle && start) begin
            k_q  <= cfg_K;
            kk_q <= W_ADDR_BITS'(cfg_K) * W_ADDR_BITS'(cfg_K);
            b_q  <= cfg_B;
         end
         if (issue && issue_src == SrcW)
            w_cnt_q <= (w_cnt_q == kk_q - 1'b1) ? '0 : w_cnt_q + 1'b1;
         if (issue && issue_src == SrcX)
            x_cnt_q <= issue_last ? '0 : x_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            buf_data_q[i] <= '0;
            buf_user_q[i] <= '0;
            buf_last_q[i] <= 1'b0;
         end
      end else begin
         if (pop) begin
            buf_data_q[0] <= buf_data_q[1];
            buf_user_q[0] <= buf_user_q[1];
            buf_last_q[0] <= buf_last_q[1];
         end
         // Incoming word lands in the first slot left free after this cycle's pop.
         if (push) begin
            if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) begin
               buf_data_q[0] <= push_data;
               buf_user_q[0] <= if_user_q;
               buf_last_q[0] <= if_last_q;
            end else begin
               buf_data_q[1] <= push_data;
               buf_user_q[1] <= if_user_q;
               buf_last_q[1] <= if_last_q;
            end
         end
         occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_conv_stream_tx.sv
// Directed bench for conv_stream_tx with behavioural W/X memories (W[a]=a+1, X[a]=1000+a).
// Also checks OUTPUT_TLAST when CONV_STREAM_TX_TLAST_EN is defined.
module tb_conv_stream_tx;

   localparam int NX = 16 * 17;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        start_ready;
   logic [3:0]  cfg_K;
   logic [23:0] cfg_B;
   logic        cfg_new_w;
   logic [6:0]  W_read_addr;
   logic [23:0] W_data;
   logic [8:0]  X_read_addr;
   logic [23:0] X_data;
   logic [23:0] OUTPUT_TDATA;
   logic        OUTPUT_TVALID;
   logic [4:0]  OUTPUT_TUSER;
   logic        OUTPUT_TREADY;
   logic        done;
`ifdef CONV_STREAM_TX_TLAST_EN
   logic        OUTPUT_TLAST;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   conv_stream_tx dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .start_ready   (start_ready),
      .cfg_K         (cfg_K),
      .cfg_B         (cfg_B),
      .cfg_new_w     (cfg_new_w),
      .W_read_addr   (W_read_addr),
      .W_data        (W_data),
      .X_read_addr   (X_read_addr),
      .X_data        (X_data),
      .OUTPUT_TDATA  (OUTPUT_TDATA),
      .OUTPUT_TVALID (OUTPUT_TVALID),
      .OUTPUT_TUSER  (OUTPUT_TUSER),
      .OUTPUT_TREADY (OUTPUT_TREADY),
      .done          (done)
`ifdef CONV_STREAM_TX_TLAST_EN
      ,
      .OUTPUT_TLAST  (OUTPUT_TLAST)
`endif
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      W_data <= 24'(W_read_addr) + 24'd1;
      X_data <= 24'(X_read_addr) + 24'd1000;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] exp_data(input int k, input bit nw, input logic [23:0] b,
                                            input int idx);
      if (nw) begin
         if (idx < k * k) return 24'(idx + 1);
         if (idx == k * k) return b;
         return 24'(1000 + idx - k * k - 1);
      end
      return 24'(1000 + idx);
   endfunction

   // One transfer: rnd randomises TREADY, pulse_cyc injects a stray start, abort_after resets
   // the DUT once that many words have been accepted.
   task automatic run(input int k, input bit nw, input logic [23:0] b, input bit rnd,
                      input int pulse_cyc, input int abort_after);
      int          n, idx, ndone;
      bit          eff_nw, stall, finished;
      logic [23:0] sd;
      logic [4:0]  su;
      eff_nw   = nw && k >= 1 && k <= 9;
      n        = eff_nw ? k * k + 1 + NX : NX;
      idx      = 0;
      ndone    = 0;
      stall    = 1'b0;
      finished = 1'b0;
      sd       = '0;
      su       = '0;
      start     = 1'b1;
      cfg_K     = 4'(k);
      cfg_B     = b;
      cfg_new_w = nw;
      OUTPUT_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (ndone > 0) begin
            chk("idle_after_done", {31'd0, start_ready}, 32'd1);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            finished = 1'b1;
            break;
         end
         if (stall)
            chk("hold_stable", {OUTPUT_TVALID, OUTPUT_TUSER, OUTPUT_TDATA}, {1'b1, su, sd});
         if (!rnd)
            chk("tvalid_contig", {31'd0, OUTPUT_TVALID}, {31'd0, (cyc >= 2 && cyc < n + 2)});
         if (cyc == pulse_cyc)
            chk("busy_not_ready", {31'd0, start_ready}, 32'd0);
         if (OUTPUT_TVALID && OUTPUT_TREADY) begin
            chk("tdata", {8'd0, OUTPUT_TDATA}, {8'd0, exp_data(k, nw && eff_nw, b, idx)});
            chk("tuser", {27'd0, OUTPUT_TUSER},
                {27'd0, (eff_nw && idx == 0) ? {4'(k), 1'b1} : 5'd0});
`ifdef CONV_STREAM_TX_TLAST_EN
            chk("tlast", {31'd0, OUTPUT_TLAST}, {31'd0, idx == n - 1});
`endif
            idx++;
            stall = 1'b0;
         end else if (OUTPUT_TVALID) begin
            stall = 1'b1;
            sd    = OUTPUT_TDATA;
            su    = OUTPUT_TUSER;
         end
         if (done) begin
            ndone++;
            chk("done_after_last", idx, n);
            if (!rnd) chk("done_cycle", cyc, n + 3);
         end
         if (abort_after > 0 && idx == abort_after) begin
            @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            chk("abort_tvalid", {31'd0, OUTPUT_TVALID}, 32'd0);
            chk("abort_ready", {31'd0, start_ready}, 32'd1);
            chk("abort_tdata", {8'd0, OUTPUT_TDATA}, 32'd0);
            chk("abort_addr", {16'd0, W_read_addr, X_read_addr}, 32'd0);
            ndone = 0;
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               if (done) ndone++;
            end
            chk("abort_no_done", ndone, 0);
            return;
         end
         @(posedge clk);
         #1;
         OUTPUT_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (cyc + 1 == pulse_cyc) begin
            start     = 1'b1;
            cfg_K     = 4'd5;
            cfg_B     = 24'd99;
            cfg_new_w = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      chk("transfer_finished", {31'd0, finished}, 32'd1);
   endtask

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      cfg_K         = '0;
      cfg_B         = '0;
      cfg_new_w     = 1'b0;
      OUTPUT_TREADY = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_tvalid", {31'd0, OUTPUT_TVALID}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ready", {31'd0, start_ready}, 32'd1);
      chk("rst_tdata", {8'd0, OUTPUT_TDATA}, 32'd0);
      chk("rst_tuser", {27'd0, OUTPUT_TUSER}, 32'd0);
      chk("rst_addr", {16'd0, W_read_addr, X_read_addr}, 32'd0);
      @(posedge clk);
      #1;
      run(3, 1'b1, -24'sd5, 1'b0, -1, 0);
      run(3, 1'b1, -24'sd5, 1'b1, -1, 0);
      run(3, 1'b0, -24'sd5, 1'b0, -1, 0);
      run(1, 1'b1, 24'd7, 1'b0, -1, 0);
      run(3, 1'b1, 24'd11, 1'b1, -1, 50);
      @(posedge clk);
      #1;
      run(2, 1'b1, 24'd42, 1'b1, -1, 0);
      run(0, 1'b1, 24'd3, 1'b0, -1, 0);
      run(3, 1'b1, 24'd21, 1'b0, 150, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
